player_stats: RTL and testbench
===============================

# player_stats

Parametrised player-stats tracker for the auto-battler game loop: holds lives, round number, coins and wins, and runs a small game-state machine (active / lost / won). Unlike a fixed-width free-running counter bank, it uses saturating arithmetic throughout, arbitrates coin spends with an explicit ok/nack handshake, and refills coins each round. It sits between the battle engine (`battle_done`, `battle_result`) and the shop logic (`spend_*`, `earn_*`), and drives the HUD/display outputs.

## Interface
- `LIVES_W`, 3: lives width.
- `INIT_LIVES`, 5: lives after reset/restart; must be ≤ 2^LIVES_W−1.
- `ROUND_W`, 8: round width.
- `COIN_W`, 10: coin width.
- `INIT_COINS`, 10: coins after reset/restart.
- `ROUND_INCOME`, 10: coins loaded at each `battle_done`.
- `MAX_COINS`, 999: coin saturation ceiling; must be ≤ 2^COIN_W−1.
- `WIN_W`, 4: wins width.
- `WINS_TO_WIN`, 10: wins that end the game victorious.
- `HEAVY_ROUND`, 5: rounds ≥ this cost 2 lives per loss, otherwise 1.
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high; all state returns to initial values.
- `restart` in 1: synchronous; same effect as reset, on the next edge.
- `battle_done` in 1: one-cycle pulse; battle finished.
- `battle_result` in 2: `battle_result_e`, sampled with `battle_done`.
- `spend_req` in 1: one-cycle purchase request.
- `spend_amt` in COIN_W: purchase price.
- `earn_req` in 1: one-cycle income request (e.g. a pet sale).
- `earn_amt` in COIN_W: income amount.
- `spend_ok` out 1: registered one-cycle pulse; purchase accepted.
- `spend_nack` out 1: registered one-cycle pulse; purchase rejected.
- `lives` out LIVES_W, `round` out ROUND_W, `coins` out COIN_W, `wins` out WIN_W: current stats.
- `state` out `game_state_e`: GS_ACTIVE, GS_LOST, GS_WON.
- `game_over` out 1: `state != GS_ACTIVE`.

## Operation
- Reset values: lives=INIT_LIVES, round=1, coins=INIT_COINS, wins=0, state=GS_ACTIVE, spend_ok=spend_nack=0.
- In GS_ACTIVE, `battle_done` has the highest priority:
  - round+1, saturating at all-ones.
  - coins ← ROUND_INCOME.
  - RES_WIN: wins+1, saturating.
  - RES_LOSS: lives − penalty, floored at 0. Penalty is 2 if the pre-increment round ≥ HEAVY_ROUND, else 1.
  - RES_DRAW: no change to lives or wins.
  - A concurrent `spend_req` is nacked; a concurrent `earn_req` is discarded.
- Without `battle_done`:
  - A spend is accepted iff `spend_amt` ≤ current coins (the pre-earn value).
  - Next coins = min(MAX_COINS, coins − accepted spend + earn). Compute at COIN_W+1 bits to avoid overflow.
  - `spend_amt` = 0 is always accepted.
- State transitions, evaluated on post-update values:
  - lives == 0 → GS_LOST.
  - wins == WINS_TO_WIN → GS_WON.
  - Both cannot occur in the same battle.
- GS_LOST and GS_WON are terminal:
  - Stats are frozen.
  - Every `spend_req` is nacked; `earn_req` and `battle_done` are ignored.
  - Exit only via `reset` or `restart`.
- `restart` overrides every other input in the same cycle.

## Timing
- Every output is registered. Stat and state updates are visible one cycle after the input edge.
- `spend_ok` or `spend_nack` pulses exactly one cycle after `spend_req`, for exactly one cycle. Exactly one of the two fires per request.
- Back-to-back requests on consecutive cycles are legal. Each is judged against the coins value updated by the previous request.
- Reset asserted mid-operation clears any pending ok/nack pulse immediately (asynchronously).

## Structure
- `stats_pkg` contains:
  - `battle_result_e` (RES_DRAW=0, RES_WIN=1, RES_LOSS=2; 3 is treated as a draw).
  - `game_state_e`.
- Sub-module `sat_counter`:
  - Parameters: W, INIT, MAX.
  - Inputs: `load`, `load_val`, `inc`, `dec` (W-bit step each), `en`.
  - Behaviour: saturates at 0 and MAX; async reset to INIT.
  - Instantiated for lives, round, wins and coins.
- Top level holds the affordability comparator, the penalty select and the FSM.

## Test plan
- Reset, then `spend_req` amt=4 three times back-to-back → coins 10→6→2→2; ok, ok, nack.
- coins=995, `earn_req` amt=20 → coins=999 (saturated); then spend 999 with earn 5 in the same cycle → ok, coins=5.
- Five losses at rounds 1–4 then 5 (HEAVY_ROUND=5) → lives 5,4,3,2,1 then 0 (floored); state=GS_LOST; later spend → nack, coins frozen.
- Ten RES_WIN battles → wins=10, state=GS_WON, round=11, coins=10; further `battle_done` ignored.
- `battle_done` plus `spend_req` plus `earn_req` in the same cycle → spend_nack, coins=ROUND_INCOME, earn discarded.
- Assert `reset` between `spend_req` and the response edge → no ok/nack pulse emitted, all outputs at initial values; `restart` in GS_LOST → GS_ACTIVE with initial stats.

Source files
------------

// File: rtl/stats_pkg.sv
// Shared types for the player-stats tracker: battle outcomes and game states.
package stats_pkg;

    // Outcome reported by the battle engine; encoding 3 behaves as a draw.
    typedef enum logic [1:0] {
        RES_DRAW = 2'd0,
        RES_WIN  = 2'd1,
        RES_LOSS = 2'd2,
        RES_RSVD = 2'd3
    } battle_result_e;

    // Game-level state; GS_LOST and GS_WON are terminal until reset/restart.
    typedef enum logic [1:0] {
        GS_ACTIVE = 2'd0,
        GS_LOST   = 2'd1,
        GS_WON    = 2'd2
    } game_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with load; clamps to [0, MAX], async reset to INIT.
module sat_counter #(
    parameter int unsigned W    = 8,
    parameter int unsigned INIT = 0,
    parameter int unsigned MAX  = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] inc,
    input  logic [W-1:0] dec,
    input  logic         en,
    output logic [W-1:0] q
);

    // One extra bit so q + inc can never wrap before clamping.
    localparam int unsigned XW = W + 1;

    logic [W-1:0]  q_q;
    logic [W-1:0]  q_d;
    logic [XW-1:0] sum_c;
    logic [XW-1:0] diff_c;
    logic [XW-1:0] sat_c;

    // Next value: load wins, otherwise clamped q + inc - dec when enabled.
    always_comb begin
        q_d    = q_q;
        sum_c  = {1'b0, q_q} + {1'b0, inc};
        diff_c = '0;
        sat_c  = '0;
        if (sum_c >= {1'b0, dec}) begin
            diff_c = sum_c - {1'b0, dec};
            sat_c  = (diff_c > XW'(MAX)) ? XW'(MAX) : diff_c;
        end
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = W'(sat_c);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= W'(INIT);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/player_stats.sv
// Player-stats tracker: lives/round/coins/wins with saturating updates,
// a spend ok/nack handshake and the active/lost/won game FSM.
module player_stats
    import stats_pkg::*;
#(
    parameter int unsigned LIVES_W      = 3,
    parameter int unsigned INIT_LIVES   = 5,
    parameter int unsigned ROUND_W      = 8,
    parameter int unsigned COIN_W       = 10,
    parameter int unsigned INIT_COINS   = 10,
    parameter int unsigned ROUND_INCOME = 10,
    parameter int unsigned MAX_COINS    = 999,
    parameter int unsigned WIN_W        = 4,
    parameter int unsigned WINS_TO_WIN  = 10,
    parameter int unsigned HEAVY_ROUND  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                restart,
    input  logic                battle_done,
    input  battle_result_e      battle_result,
    input  logic                spend_req,
    input  logic [COIN_W-1:0]   spend_amt,
    input  logic                earn_req,
    input  logic [COIN_W-1:0]   earn_amt,
    output logic                spend_ok,
    output logic                spend_nack,
    output logic [LIVES_W-1:0]  lives,
    output logic [ROUND_W-1:0]  round,
    output logic [COIN_W-1:0]   coins,
    output logic [WIN_W-1:0]    wins,
    output game_state_e         state,
    output logic                game_over
);

    localparam int unsigned LIVES_MAX = (1 << LIVES_W) - 1;
    localparam int unsigned ROUND_MAX = (1 << ROUND_W) - 1;
    localparam int unsigned WIN_MAX   = (1 << WIN_W) - 1;

    game_state_e          state_q, state_d;
    logic                 spend_ok_q, spend_ok_d;
    logic                 spend_nack_q, spend_nack_d;
    logic                 game_over_q, game_over_d;

    logic [LIVES_W-1:0]   lives_q;
    logic [ROUND_W-1:0]   round_q;
    logic [COIN_W-1:0]    coins_q;
    logic [WIN_W-1:0]     wins_q;

    logic                 active_c;
    logic                 battle_c;
    logic                 is_win_c;
    logic                 is_loss_c;
    logic                 afford_c;
    logic                 accept_c;
    logic [LIVES_W-1:0]   penalty_c;
    logic                 dies_c;
    logic                 final_win_c;
    logic                 coin_load_c;
    logic [COIN_W-1:0]    coin_load_val_c;
    logic [COIN_W-1:0]    coin_inc_c;
    logic [COIN_W-1:0]    coin_dec_c;

    // Event decode, affordability comparator and loss-penalty select.
    always_comb begin
        active_c        = (state_q == GS_ACTIVE);
        battle_c        = active_c & battle_done & ~restart;
        is_win_c        = (battle_result == RES_WIN);
        is_loss_c       = (battle_result == RES_LOSS);
        afford_c        = (spend_amt <= coins_q);
        accept_c        = active_c & spend_req & ~battle_done & ~restart & afford_c;
        penalty_c       = (round_q >= ROUND_W'(HEAVY_ROUND)) ? LIVES_W'(2) : LIVES_W'(1);
        dies_c          = is_loss_c & (lives_q <= penalty_c);
        final_win_c     = is_win_c & (({1'b0, wins_q} + (WIN_W+1)'(1)) == (WIN_W+1)'(WINS_TO_WIN));
        coin_load_c     = restart | battle_c;
        coin_load_val_c = restart ? COIN_W'(INIT_COINS) : COIN_W'(ROUND_INCOME);
        coin_inc_c      = earn_req ? earn_amt : COIN_W'(0);
        coin_dec_c      = accept_c ? spend_amt : COIN_W'(0);
    end

    sat_counter #(.W(LIVES_W), .INIT(INIT_LIVES), .MAX(LIVES_MAX)) u_lives (
        .clk      (clk),
        .reset    (reset),
        .load     (restart),
        .load_val (LIVES_W'(INIT_LIVES)),
        .inc      (LIVES_W'(0)),
        .dec      (penalty_c),
        .en       (battle_c & is_loss_c),
        .q        (lives_q)
    );

    sat_counter #(.W(ROUND_W), .INIT(1), .MAX(ROUND_MAX)) u_round (
        .clk      (clk),
        .reset    (reset),
        .load     (restart),
        .load_val (ROUND_W'(1)),
        .inc      (ROUND_W'(1)),
        .dec      (ROUND_W'(0)),
        .en       (battle_c),
        .q        (round_q)
    );

    sat_counter #(.W(WIN_W), .INIT(0), .MAX(WIN_MAX)) u_wins (
        .clk      (clk),
        .reset    (reset),
        .load     (restart),
        .load_val (WIN_W'(0)),
        .inc      (WIN_W'(1)),
        .dec      (WIN_W'(0)),
        .en       (battle_c & is_win_c),
        .q        (wins_q)
    );

    // Coins: reloaded on restart/battle, otherwise spend/earn clamped to MAX_COINS.
    sat_counter #(.W(COIN_W), .INIT(INIT_COINS), .MAX(MAX_COINS)) u_coins (
        .clk      (clk),
        .reset    (reset),
        .load     (coin_load_c),
        .load_val (coin_load_val_c),
        .inc      (coin_inc_c),
        .dec      (coin_dec_c),
        .en       (active_c & ~battle_done),
        .q        (coins_q)
    );

    // Game FSM next state and spend handshake outputs.
    always_comb begin
        state_d      = state_q;
        spend_ok_d   = 1'b0;
        spend_nack_d = 1'b0;
        if (restart) begin
            state_d = GS_ACTIVE;
        end else begin
            spend_ok_d   = accept_c;
            spend_nack_d = spend_req & ~accept_c;
            case (state_q)
                GS_ACTIVE: begin
                    if (battle_c) begin
                        if (dies_c) begin
                            state_d = GS_LOST;
                        end else if (final_win_c) begin
                            state_d = GS_WON;
                        end
                    end
                end
                GS_LOST:  state_d = GS_LOST;
                GS_WON:   state_d = GS_WON;
                default:  state_d = GS_ACTIVE;
            endcase
        end
        game_over_d = (state_d != GS_ACTIVE);
    end

    // FSM state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= GS_ACTIVE;
            spend_ok_q   <= 1'b0;
            spend_nack_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            spend_ok_q   <= spend_ok_d;
            spend_nack_q <= spend_nack_d;
            game_over_q  <= game_over_d;
        end
    end

    assign spend_ok   = spend_ok_q;
    assign spend_nack = spend_nack_q;
    assign lives      = lives_q;
    assign round      = round_q;
    assign coins      = coins_q;
    assign wins       = wins_q;
    assign state      = state_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_player_stats.sv
// Directed bench for player_stats with a reference model feeding a scoreboard.
module tb_player_stats;
    import stats_pkg::*;

    logic           clk;
    logic           reset;
    logic           restart;
    logic           battle_done;
    battle_result_e battle_result;
    logic           spend_req;
    logic [9:0]     spend_amt;
    logic           earn_req;
    logic [9:0]     earn_amt;
    logic           spend_ok;
    logic           spend_nack;
    logic [2:0]     lives;
    logic [7:0]     round;
    logic [9:0]     coins;
    logic [3:0]     wins;
    game_state_e    state;
    logic           game_over;

    typedef struct {
        logic        ok;
        logic        nack;
        int          lives;
        int          round;
        int          coins;
        int          wins;
        game_state_e st;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    int          m_lives;
    int          m_round;
    int          m_coins;
    int          m_wins;
    game_state_e m_st;

    player_stats dut (
        .clk           (clk),
        .reset         (reset),
        .restart       (restart),
        .battle_done   (battle_done),
        .battle_result (battle_result),
        .spend_req     (spend_req),
        .spend_amt     (spend_amt),
        .earn_req      (earn_req),
        .earn_amt      (earn_amt),
        .spend_ok      (spend_ok),
        .spend_nack    (spend_nack),
        .lives         (lives),
        .round         (round),
        .coins         (coins),
        .wins          (wins),
        .state         (state),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lives = 5;
        m_round = 1;
        m_coins = 10;
        m_wins  = 0;
        m_st    = GS_ACTIVE;
    endtask

    task automatic push_exp(input logic ok, input logic nack);
        exp_t e;
        e.ok    = ok;
        e.nack  = nack;
        e.lives = m_lives;
        e.round = m_round;
        e.coins = m_coins;
        e.wins  = m_wins;
        e.st    = m_st;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".ok"},    32'(spend_ok),   32'(e.ok));
            chk({tag, ".nack"},  32'(spend_nack), 32'(e.nack));
            chk({tag, ".lives"}, 32'(lives),      32'(e.lives));
            chk({tag, ".round"}, 32'(round),      32'(e.round));
            chk({tag, ".coins"}, 32'(coins),      32'(e.coins));
            chk({tag, ".wins"},  32'(wins),       32'(e.wins));
            chk({tag, ".state"}, 32'(state),      32'(e.st));
            chk({tag, ".over"},  32'(game_over),  32'(e.st != GS_ACTIVE));
        end
    endtask

    task automatic clear_inputs();
        restart       = 1'b0;
        battle_done   = 1'b0;
        battle_result = RES_DRAW;
        spend_req     = 1'b0;
        spend_amt     = '0;
        earn_req      = 1'b0;
        earn_amt      = '0;
    endtask

    // One clock of stimulus; the model predicts, the DUT is compared #1 after the edge.
    task automatic step(input string tag, input bit bd, input battle_result_e br,
                        input bit sr, input int sa, input bit er, input int ea, input bit rs);
        logic ok;
        logic nack;
        int   pen;
        int   tmp;
        @(negedge clk);
        battle_done   = bd;
        battle_result = br;
        spend_req     = sr;
        spend_amt     = 10'(sa);
        earn_req      = er;
        earn_amt      = 10'(ea);
        restart       = rs;
        ok   = 1'b0;
        nack = 1'b0;
        if (rs) begin
            model_reset();
        end else if (m_st != GS_ACTIVE) begin
            nack = sr;
        end else if (bd) begin
            nack    = sr;
            pen     = (m_round >= 5) ? 2 : 1;
            m_round = (m_round < 255) ? m_round + 1 : 255;
            m_coins = 10;
            if (br == RES_WIN) m_wins = (m_wins < 15) ? m_wins + 1 : 15;
            else if (br == RES_LOSS) m_lives = (m_lives > pen) ? m_lives - pen : 0;
            if (m_lives == 0) m_st = GS_LOST;
            else if (m_wins == 10) m_st = GS_WON;
        end else begin
            ok      = sr && (sa <= m_coins);
            nack    = sr && !ok;
            tmp     = m_coins - (ok ? sa : 0) + (er ? ea : 0);
            m_coins = (tmp > 999) ? 999 : tmp;
        end
        push_exp(ok, nack);
        @(posedge clk);
        #1;
        clear_inputs();
        check_out(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, RES_DRAW, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #12;
        model_reset();
        push_exp(1'b0, 1'b0);
        check_out("reset");
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back spends against shrinking coins.
        step("spend4a", 1'b0, RES_DRAW, 1'b1, 4, 1'b0, 0, 1'b0);
        step("spend4b", 1'b0, RES_DRAW, 1'b1, 4, 1'b0, 0, 1'b0);
        step("spend4c", 1'b0, RES_DRAW, 1'b1, 4, 1'b0, 0, 1'b0);
        idle("idle1");

        // Earn up to the ceiling, then spend all while earning.
        step("earn993", 1'b0, RES_DRAW, 1'b0, 0, 1'b1, 993, 1'b0);
        step("earnsat", 1'b0, RES_DRAW, 1'b0, 0, 1'b1, 20, 1'b0);
        step("spend999", 1'b0, RES_DRAW, 1'b1, 999, 1'b1, 5, 1'b0);
        step("spend0", 1'b0, RES_DRAW, 1'b1, 0, 1'b0, 0, 1'b0);
        step("spend6", 1'b0, RES_DRAW, 1'b1, 6, 1'b0, 0, 1'b0);
        step("spend5", 1'b0, RES_DRAW, 1'b1, 5, 1'b0, 0, 1'b0);

        // Losses with heavy-round penalty; game lost and frozen.
        step("restart1", 1'b0, RES_DRAW, 1'b0, 0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step("loss", 1'b1, RES_LOSS, 1'b0, 0, 1'b0, 0, 1'b0);
        end
        step("lost_spend", 1'b0, RES_DRAW, 1'b1, 3, 1'b0, 0, 1'b0);
        step("lost_earn", 1'b0, RES_DRAW, 1'b0, 0, 1'b1, 50, 1'b0);
        step("lost_battle", 1'b1, RES_WIN, 1'b0, 0, 1'b0, 0, 1'b0);
        step("lost_restart", 1'b1, RES_LOSS, 1'b1, 2, 1'b1, 9, 1'b1);

        // Ten wins to victory, then further battles ignored.
        for (int i = 0; i < 10; i++) begin
            step("win", 1'b1, RES_WIN, 1'b0, 0, 1'b0, 0, 1'b0);
        end
        step("won_battle", 1'b1, RES_WIN, 1'b0, 0, 1'b0, 0, 1'b0);
        step("won_spend", 1'b0, RES_DRAW, 1'b1, 1, 1'b0, 0, 1'b0);

        // Battle collides with spend and earn; reserved result acts as draw.
        step("restart2", 1'b0, RES_DRAW, 1'b0, 0, 1'b0, 0, 1'b1);
        step("earn30", 1'b0, RES_DRAW, 1'b0, 0, 1'b1, 30, 1'b0);
        step("bd_collide", 1'b1, RES_DRAW, 1'b1, 4, 1'b1, 7, 1'b0);
        step("bd_rsvd", 1'b1, RES_RSVD, 1'b0, 0, 1'b0, 0, 1'b0);
        step("rs_spend", 1'b0, RES_DRAW, 1'b1, 1, 1'b1, 3, 1'b1);

        // Async reset between a spend request and its response edge.
        step("pre_rst", 1'b1, RES_WIN, 1'b0, 0, 1'b0, 0, 1'b0);
        @(negedge clk);
        spend_req = 1'b1;
        spend_amt = 10'd4;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        push_exp(1'b0, 1'b0);
        check_out("rst_mid");
        @(posedge clk);
        #1;
        push_exp(1'b0, 1'b0);
        check_out("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();

        // Async reset clears a visible ok pulse immediately.
        step("pulse", 1'b0, RES_DRAW, 1'b1, 4, 1'b0, 0, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        push_exp(1'b0, 1'b0);
        check_out("rst_pulse");
        @(negedge clk);
        reset = 1'b0;
        idle("idle_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
